// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and sizing for the round-robin four-way byte-stream arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side and downstream stream signals of the arbiter, bundled with
// modports for the arbiter (slave) and the surrounding fabric (master).
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;
    logic [DATA_W-1:0]  req_data0;
    logic [DATA_W-1:0]  req_data1;
    logic [DATA_W-1:0]  req_data2;
    logic [DATA_W-1:0]  req_data3;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic               out_ready;

    modport slave (
        input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        output req_ready, out_valid, out_data, out_last
    );

    modport master (
        output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// Existing four-to-one byte multiplexer shared by the four requesters.
module four_one_mux #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    // Select one of four data inputs
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter: grants one of four requesters per burst and
// forwards its stream through four_one_mux with zero-latency handshaking.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    mux_rr_arbiter_if.slave    bus,
    output logic [SEL_W-1:0]   selector,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               burst_overflow
);

    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    arb_state_e         state_r, state_s;
    logic [SEL_W-1:0]   sel_r, sel_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic [SEL_W-1:0]   last_winner_r, last_winner_s;
    logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_s;
    logic               busy_r;
    logic               ovf_r, ovf_s;
    logic [DATA_W-1:0]  mux_data_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               beat_s;

    // Scan last+1 .. last+4; iterating downward lets the nearest requester win.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        rr_pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (vld[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    four_one_mux #(.W(DATA_W)) u_mux (
        .d0  (bus.req_data0),
        .d1  (bus.req_data1),
        .d2  (bus.req_data2),
        .d3  (bus.req_data3),
        .sel (sel_r),
        .y   (mux_data_s)
    );

    // Zero-latency forwarding of the owner's stream while a burst is active
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = mux_data_s;
        ready_s       = {NUM_REQ{1'b0}};
        if (state_r == BURST) begin
            bus.out_valid  = bus.req_valid[sel_r];
            bus.out_last   = bus.req_last[sel_r];
            ready_s[sel_r] = bus.out_ready;
        end else begin
            bus.out_valid = 1'b0;
        end
    end

    assign bus.req_ready = ready_s;
    assign beat_s        = bus.out_valid & bus.out_ready;

    // Next-state, grant, rotation pointer and beat counter
    always_comb begin
        state_s       = state_r;
        sel_s         = sel_r;
        grant_s       = grant_r;
        last_winner_s = last_winner_r;
        beat_cnt_s    = beat_cnt_r;
        ovf_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (|bus.req_valid) begin
                    sel_s   = rr_pick(bus.req_valid, last_winner_r);
                    grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (beat_s) begin
                    if (bus.out_last || (beat_cnt_r + 8'd1 == MAX_BURST_C)) begin
                        // selector is left as-is; only the grant is dropped
                        state_s       = IDLE;
                        last_winner_s = sel_r;
                        grant_s       = {NUM_REQ{1'b0}};
                        beat_cnt_s    = 8'd0;
                        ovf_s         = ~bus.out_last;
                    end else begin
                        beat_cnt_s = beat_cnt_r + 8'd1;
                    end
                end else begin
                    state_s = BURST;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = {NUM_REQ{1'b0}};
                beat_cnt_s = 8'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            sel_r         <= 2'd0;
            grant_r       <= 4'b0000;
            last_winner_r <= 2'd3;
            beat_cnt_r    <= 8'd0;
            busy_r        <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            sel_r         <= sel_s;
            grant_r       <= grant_s;
            last_winner_r <= last_winner_s;
            beat_cnt_r    <= beat_cnt_s;
            busy_r        <= (state_s == BURST);
            ovf_r         <= ovf_s;
        end
    end

    assign selector       = sel_r;
    assign grant          = grant_r;
    assign busy           = busy_r;
    assign burst_overflow = ovf_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: table of single-cycle vectors plus
// hand-written burst, overflow and mid-burst reset sequences.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       reset_n;
    logic [1:0] selector;
    logic [3:0] grant;
    logic       busy;
    logic       burst_overflow;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .selector       (selector),
        .grant          (grant),
        .busy           (busy),
        .burst_overflow (burst_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic [3:0] eg;
        logic [1:0] es;
        logic       eb;
        logic       eov;
        logic [7:0] ed;
        logic       el;
        logic [3:0] er;
        logic       eovf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [7:0] dat3 [4];
        logic [7:0] rec  [8];
        int         pat  [5];
        int         beat;
        int         n;
        int         ovf_cnt;
        int         ovf_beat;
        int         regrant;
        logic       xfer;
        logic [7:0] xdata;

        tbl[0] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 4'b0001, 1'b0};
        tbl[1] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'b0000, 1'b0};
        tbl[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11, 1'b1, 4'b0010, 1'b0};
        tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h11, 1'b0, 4'b0000, 1'b0};
        tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h22, 1'b1, 4'b0100, 1'b0};
        tbl[5] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h22, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h33, 1'b1, 4'b1000, 1'b0};
        tbl[7] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h33, 1'b0, 4'b0000, 1'b0};
        tbl[8] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 4'b0001, 1'b0};
        tbl[9] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'b0000, 1'b0};

        reset_n       = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        bus.req_data0 = 8'hA5;
        bus.req_data1 = 8'h11;
        bus.req_data2 = 8'h22;
        bus.req_data3 = 8'h33;
        bus.out_ready = 1'b0;
        #12;
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset selector", 32'(selector), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset overflow", 32'(burst_overflow), 32'h0);
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-beat grant then strict rotation with an idle gap between grants
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = tbl[i].vld;
            bus.req_last  = tbl[i].lst;
            bus.out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].eg));
            chk($sformatf("row%0d selector", i), 32'(selector), 32'(tbl[i].es));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].eov));
            if (tbl[i].eov) begin
                chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].ed));
            end
            chk($sformatf("row%0d out_last", i), 32'(bus.out_last), 32'(tbl[i].el));
            chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].er));
            chk($sformatf("row%0d overflow", i), 32'(burst_overflow), 32'(tbl[i].eovf));
        end

        // Owner 2, three beats under a toggling downstream ready
        dat3[0] = 8'hC1; dat3[1] = 8'hC2; dat3[2] = 8'hC3; dat3[3] = 8'h00;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0000;
        bus.req_data2 = dat3[0];
        bus.out_ready = 1'b0;
        tick();
        chk("t3 grant", 32'(grant), 32'h4);
        chk("t3 selector", 32'(selector), 32'h2);
        beat = 0;
        n    = 0;
        for (int k = 0; k < 5; k++) begin
            bus.out_ready = (pat[k] != 0);
            bus.req_data2 = dat3[beat];
            bus.req_last  = (beat == 2) ? 4'b0100 : 4'b0000;
            #1;
            chk($sformatf("t3 req_ready k%0d", k), 32'(bus.req_ready), (pat[k] != 0) ? 32'h4 : 32'h0);
            xfer  = bus.out_valid && bus.out_ready;
            xdata = bus.out_data;
            tick();
            if (xfer) begin
                rec[n] = xdata;
                n++;
                beat++;
            end
            chk($sformatf("t3 overflow k%0d", k), 32'(burst_overflow), 32'h0);
        end
        chk("t3 transfers", 32'(n), 32'd3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t3 data%0d", j), 32'(rec[j]), 32'(dat3[j]));
        end
        chk("t3 grant released", 32'(grant), 32'h0);

        // Requester 1 streams 6 beats; MAX_BURST=4 forces a release after beat 4
        bus.out_ready = 1'b1;
        beat     = 0;
        n        = 0;
        ovf_cnt  = 0;
        ovf_beat = -1;
        regrant  = 0;
        for (int c = 0; c < 12; c++) begin
            bus.req_data1 = 8'h40 + 8'(beat);
            bus.req_last  = (beat == 5) ? 4'b0010 : 4'b0000;
            bus.req_valid = (beat < 6) ? 4'b0010 : 4'b0000;
            #1;
            xfer  = bus.out_valid && bus.out_ready;
            xdata = bus.out_data;
            tick();
            if (xfer) begin
                if (n < 8) rec[n] = xdata;
                n++;
                beat++;
            end
            if (burst_overflow) begin
                ovf_cnt++;
                ovf_beat = beat;
            end
            if (ovf_cnt > 0 && grant == 4'b0010) regrant = 1;
        end
        chk("t4 beats", 32'(n), 32'd6);
        chk("t4 overflow pulses", 32'(ovf_cnt), 32'd1);
        chk("t4 overflow beat", 32'(ovf_beat), 32'd4);
        chk("t4 regrant to 1", 32'(regrant), 32'd1);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t4 data%0d", j), 32'(rec[j]), 32'(8'h40 + 8'(j)));
        end
        chk("t4 idle at end", 32'(grant), 32'h0);

        // Reset in the middle of a burst, then requester 0 regains first priority
        bus.req_valid = 4'b1100;
        bus.req_last  = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        chk("t5 grant before reset", 32'(grant), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5 grant async", 32'(grant), 32'h0);
        chk("t5 req_ready async", 32'(bus.req_ready), 32'h0);
        chk("t5 out_valid async", 32'(bus.out_valid), 32'h0);
        chk("t5 busy async", 32'(busy), 32'h0);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        reset_n = 1'b1;
        tick();
        chk("t5 grant after reset", 32'(grant), 32'h1);
        chk("t5 selector after reset", 32'(selector), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
